// File: rtl/frame_pkg.sv
// frame_pkg: constants, state encoding and the CRC-16/XMODEM word step shared
// by frame_encoder and frame_detector.
package frame_pkg;

    localparam logic [31:0] FRAME_HEADER  = 32'hE0E0E0E0;
    localparam logic [31:0] FRAME_TRAILER = 32'h0E0E0E0E;
    localparam int          MAX_WORDS     = 8;
    localparam logic [15:0] CRC16_POLY    = 16'h1021;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_LOAD = 4'd1,
        ST_HDR0 = 4'd2,
        ST_HDR1 = 4'd3,
        ST_CHAN = 4'd4,
        ST_DATA = 4'd5,
        ST_CRC  = 4'd6,
        ST_TRL0 = 4'd7,
        ST_TRL1 = 4'd8,
        ST_GAP  = 4'd9
    } fenc_state_t;

    // One 16-bit word, MSB first, init/xorout handled by the caller (XMODEM: 0/0).
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic [15:0] word);
        logic [15:0] c;
        c = crc ^ word;
        for (int i = 0; i < 16; i++) begin
            c = c[15] ? ({c[14:0], 1'b0} ^ CRC16_POLY) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_d16.sv
// crc16_d16: combinational single-word CRC-16/XMODEM step.
module crc16_d16
    import frame_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [15:0] data_i,
    output logic [15:0] crc_o
);

    assign crc_o = crc16_step(crc_i, data_i);

endmodule

// File: rtl/frame_encoder.sv
// frame_encoder: buffers up to eight payload words, then emits a gap-free
// header / channel / payload / CRC / trailer stream followed by IDLE_GAP zeros.
// Optional feature macro FRAME_ENC_CRC_INJECT_EN adds the crc_corrupt input,
// which inverts the emitted CRC word of the accepted frame.
module frame_encoder
    import frame_pkg::*;
#(
    parameter int unsigned IDLE_GAP = 1
)
(
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_chan,
    input  logic [2:0]  cmd_len,
    input  logic        pld_valid,
    output logic        pld_ready,
    input  logic [15:0] pld_data,
`ifdef FRAME_ENC_CRC_INJECT_EN
    input  logic        crc_corrupt,
`endif
    output logic [15:0] data_out,
    output logic        frame_active,
    output logic        cmd_err
);

    fenc_state_t state_q, state_d;
    logic [7:0]  chan_q, chan_d;
    logic [2:0]  len_q, len_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  gap_q, gap_d;
    logic [15:0] crc_q, crc_d;
    logic        inv_q, inv_d;
    logic [15:0] data_q, data_d;
    logic        active_q, active_d;
    logic        err_q, err_d;
    logic        buf_we;
    logic        corrupt_in;
    logic [15:0] crc_next;
    logic [15:0] buf_q [MAX_WORDS];

`ifdef FRAME_ENC_CRC_INJECT_EN
    assign corrupt_in = crc_corrupt;
`else
    assign corrupt_in = 1'b0;
`endif

    crc16_d16 u_crc (
        .crc_i  (crc_q),
        .data_i (pld_data),
        .crc_o  (crc_next)
    );

    // Handshake outputs decode straight from the registered state; ready is
    // held low while reset is asserted.
    assign cmd_ready    = (state_q == ST_IDLE) && rst_n;
    assign pld_ready    = (state_q == ST_LOAD);
    assign data_out     = data_q;
    assign frame_active = active_q;
    assign cmd_err      = err_q;

    // Next-state logic; data_d is the word the next state will present, so
    // the registered output lines up with the state that owns it.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d = state_q;
        chan_d  = chan_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        crc_d   = crc_q;
        inv_d   = inv_q;
        data_d  = 16'h0000;
        err_d   = 1'b0;
        buf_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    chan_d = cmd_chan;
                    len_d  = cmd_len;
                    inv_d  = corrupt_in;
                    crc_d  = 16'h0000;
                    cnt_d  = 3'd0;
                    if ($countones(cmd_chan) != 1) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (pld_valid) begin
                    buf_we = 1'b1;
                    crc_d  = crc_next;
                    if (cnt_q == len_q) begin
                        cnt_d   = 3'd0;
                        state_d = ST_HDR0;
                        data_d  = FRAME_HEADER[31:16];
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            ST_HDR0: begin
                state_d = ST_HDR1;
                data_d  = FRAME_HEADER[15:0];
            end
            ST_HDR1: begin
                state_d = ST_CHAN;
                data_d  = {8'h00, chan_q};
            end
            ST_CHAN: begin
                state_d = ST_DATA;
                cnt_d   = 3'd0;
                data_d  = buf_q[0];
            end
            ST_DATA: begin
                if (cnt_q == len_q) begin
                    state_d = ST_CRC;
                    data_d  = crc_q ^ {16{inv_q}};
                end else begin
                    cnt_d  = cnt_q + 3'd1;
                    data_d = buf_q[cnt_q + 3'd1];
                end
            end
            ST_CRC: begin
                state_d = ST_TRL0;
                data_d  = FRAME_TRAILER[31:16];
            end
            ST_TRL0: begin
                state_d = ST_TRL1;
                data_d  = FRAME_TRAILER[15:0];
            end
            ST_TRL1: begin
                state_d = ST_GAP;
                gap_d   = 4'd1;
            end
            ST_GAP: begin
                if (gap_q == 4'(IDLE_GAP)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // frame_active covers the header through the trailer of the next state.
    always_comb begin
        active_d = (state_d inside {ST_HDR0, ST_HDR1, ST_CHAN, ST_DATA,
                                    ST_CRC, ST_TRL0, ST_TRL1});
    end

    // Control and output registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            chan_q   <= 8'h00;
            len_q    <= 3'd0;
            cnt_q    <= 3'd0;
            gap_q    <= 4'd0;
            crc_q    <= 16'h0000;
            inv_q    <= 1'b0;
            data_q   <= 16'h0000;
            active_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            crc_q    <= crc_d;
            inv_q    <= inv_d;
            data_q   <= data_d;
            active_q <= active_d;
            err_q    <= err_d;
        end
    end

    // Payload buffer write port.
    always_ff @(posedge clk_in) begin
        // NOTE: the buffer is not reset; every word is written before it is read.
        if (buf_we) begin
            buf_q[cnt_q] <= pld_data;
        end
    end

endmodule
